fifo_stream_reader: RTL and testbench

// - Read-side engine for the 8-bit synchronous FIFO. Sits between the FIFO read port and a downstream consumer.
// - Pops words whenever the FIFO is non-empty and buffer space allows, absorbing the FIFO's 1-cycle registered read latency.
// - Presents words on a valid/ready stream with full 1-word/cycle throughput and no loss under backpressure.

---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the 8-bit synchronous FIFO: absorbs the 1-cycle read latency in a 2-entry skid buffer.
// Define FIFO_RD_FRAME_EN to generate m_last every FRAME_LEN words; otherwise m_last is tied low.
module fifo_stream_reader #(
    parameter int DW        = 8,
    parameter int CW        = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [CW-1:0] rd_count,
    output logic          busy
);

    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("FRAME_LEN must be >= 1");
    end

    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    logic [2:0]    owed;

    assign pop        = m_valid & m_ready;
    // Words held plus words still owed by the FIFO, after this cycle's handshake.
    assign owed       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_rd_en = en & ~fifo_empty & ~rst & (owed < 3'd2);

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign rd_count = cnt_q;
    assign busy     = inflight_q | (occ_q != 2'd0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rd_en;
        cnt_d      = cnt_q + CW'(pop);
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop && occ_q == 2'd2)
            head_d = tail_q;
        // Returning word lands at the head if the head is free (or leaving), else behind it.
        if (inflight_q) begin
            if (occ_q == 2'd0 || (occ_q == 2'd1 && pop))
                head_d = fifo_data;
            else
                tail_d = fifo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef FIFO_RD_FRAME_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [BW-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop)
            beat_d = (beat_q == BW'(FRAME_LEN - 1)) ? '0 : beat_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            beat_q <= '0;
        else
            beat_q <= beat_d;
    end

    // The head word's frame index is always the handshake count, so its last flag follows it out.
    assign m_last = m_valid & (beat_q == BW'(FRAME_LEN - 1));
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model feeding the reader, expected words kept in a queue.
// Works with or without FIFO_RD_FRAME_EN.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int FL = 4;
`ifdef FIFO_RD_FRAME_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, en, m_ready;
    logic          fifo_empty, fifo_rd_en, m_valid, m_last, busy;
    logic [DW-1:0] fifo_data = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DW(DW), .CW(CW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .rd_count(rd_count), .busy(busy)
    );

    // FIFO model: registered read data, flushed by the same reset as the reader.
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr = '0;
    logic [7:0]    rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];
    int exp_cnt = 0;
    int n_reads = 0;
    int n_last = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_last(input int n);
        return FRAME_EN && ((n % FL) == FL - 1);
    endfunction

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(v);
    endtask

    // One cycle: inputs were set at the preceding negedge; check, then advance to the next negedge.
    task automatic step();
        #1;
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (fifo_rd_en === 1'b1) n_reads++;
        if (m_valid === 1'b1 && m_ready === 1'b1 && !rst) begin
            chk("hs_present", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("hs_data", m_data, exp_q[0]);
                chk("hs_last", m_last, exp_last(exp_cnt));
                void'(exp_q.pop_front());
            end
            exp_cnt++;
            if (m_last === 1'b1) n_last++;
        end
        prev_stall = !rst && m_valid === 1'b1 && m_ready === 1'b0;
        prev_data  = m_data;
        prev_last  = m_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        chk(tag, exp_q.size(), 0);
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);

        // single word: read at t, visible at t+2
        push(8'hA5); en = 1'b1; m_ready = 1'b1;
        #1 chk("single_rd_t", fifo_rd_en, 1);
        step();
        chk("single_rd_t1", fifo_rd_en, 0);
        chk("single_valid_t1", m_valid, 0);
        step();
        chk("single_valid_t2", m_valid, 1);
        chk("single_data_t2", m_data, 8'hA5);
        step();
        chk("single_count", rd_count, 1);
        chk("single_idle", busy, 0);

        // burst of 16, one handshake per cycle
        for (int i = 0; i < 16; i++) push(8'(i));
        step(); step();
        for (int i = 0; i < 16; i++) begin
            chk("burst_nogap", m_valid, 1);
            step();
        end
        chk("burst_empty", exp_q.size(), 0);
        chk("burst_count", rd_count, exp_cnt[CW-1:0]);
        chk("burst_idle", busy, 0);

        // backpressure for 5 cycles mid-burst
        for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
        repeat (5) step();
        m_ready = 1'b0; n_reads = 0;
        repeat (5) step();
        chk("bp_reads_le2", n_reads <= 2, 1);
        chk("bp_busy", busy, 1);
        chk("bp_head", m_data, 8'h23);
        m_ready = 1'b1;
        drain("bp_drained");
        chk("bp_count", rd_count, exp_cnt[CW-1:0]);

        // en dropped mid-burst, then restored
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        repeat (4) step();
        en = 1'b0; n_reads = 0;
        repeat (5) step();
        chk("en_off_reads", n_reads, 0);
        chk("en_off_busy", busy, 0);
        chk("en_off_valid", m_valid, 0);
        chk("en_off_left", exp_q.size(), 4);
        en = 1'b1;
        drain("en_drained");
        chk("en_count", rd_count, exp_cnt[CW-1:0]);

        // reset mid-burst discards everything
        for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
        repeat (5) step();
        rst = 1'b1; m_ready = 1'b0;
        #1 chk("rst_mid_rd_en", fifo_rd_en, 0);
        exp_q.delete(); exp_cnt = 0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_rd_en2", fifo_rd_en, 0);
        chk("rst_mid_count", rd_count, 0);
        chk("rst_mid_busy", busy, 0);

        // 17-word frame run: m_last on words 3,7,11,15 with framing, count wraps to 1
        n_last = 0; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        drain("frame_drained");
        chk("frame_words", exp_cnt, 17);
        chk("frame_lasts", n_last, FRAME_EN ? 4 : 0);
        chk("frame_count_wrap", rd_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
